// File: rtl/sw_host_driver.sv
// sw_host_driver
//   Command-driven host front end for the Smith-Waterman accelerator.
//   Commands: SET_PARAM pushes scoring parameters, LOAD_T streams the target
//   sequence words, RUN starts a calculation and serves S-base chunks on the
//   accelerator's request until it reports a result.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid_i/cmd_ready_o/cmd_op_i   command handshake and opcode
//   cfg_*_i                         scoring parameters, sampled on SET_PARAM
//   t_data_i/t_valid_i/t_last_i/t_ready_o   T-word stream
//   s_base_i/s_valid_i/s_last_i/s_ready_o   S-base stream
//   acc_*_o                         accelerator control/data (all registered)
//   acc_request_s_i, acc_busy_i, acc_valid_i, acc_result_i   accelerator status
//   res_data_o/res_valid_o          captured score
//   err_o                           sticky T-stream gap error
//
// state  | meaning
// IDLE   | accepting commands when accelerator not busy
// PARAM  | acc_param_valid pulse cycle
// TLOAD  | streaming T words, one per cycle
// TEND   | last word on acc_t; terminator follows
// TWAIT  | waiting for accelerator to digest T (busy high then low, or timeout)
// RSTART | acc_start_cal pulse cycle
// RUN    | serving S chunks, waiting for acc_valid
// DRAIN  | result captured, waiting for acc_busy low
module sw_host_driver #(
   parameter int PE_SIZE   = 8,
   parameter int PE_LOG    = 3,
   parameter int VEF_BIT   = 12,
   parameter int MATCH_BIT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [1:0]             cmd_op_i,
   input  logic [MATCH_BIT-1:0]   cfg_match_i,
   input  logic [MATCH_BIT-1:0]   cfg_mismatch_i,
   input  logic [7:0]             cfg_alpha_i,
   input  logic [7:0]             cfg_beta_i,
   input  logic [17:0]            t_data_i,
   input  logic                   t_valid_i,
   input  logic                   t_last_i,
   output logic                   t_ready_o,
   input  logic [1:0]             s_base_i,
   input  logic                   s_valid_i,
   input  logic                   s_last_i,
   output logic                   s_ready_o,
   output logic                   acc_set_t_o,
   output logic                   acc_start_cal_o,
   output logic                   acc_param_valid_o,
   output logic [17:0]            acc_t_o,
   output logic [MATCH_BIT-1:0]   acc_match_o,
   output logic [MATCH_BIT-1:0]   acc_mismatch_o,
   output logic [7:0]             acc_alpha_o,
   output logic [7:0]             acc_beta_o,
   output logic [2*PE_SIZE-1:0]   acc_s_o,
   output logic [PE_LOG:0]        acc_s_valid_o,
   input  logic                   acc_request_s_i,
   input  logic                   acc_busy_i,
   input  logic                   acc_valid_i,
   input  logic [VEF_BIT-1:0]     acc_result_i,
   output logic [VEF_BIT-1:0]     res_data_o,
   output logic                   res_valid_o,
   output logic                   err_o
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] PARAM  = 3'd1;
   localparam logic [2:0] TLOAD  = 3'd2;
   localparam logic [2:0] TEND   = 3'd3;
   localparam logic [2:0] TWAIT  = 3'd4;
   localparam logic [2:0] RSTART = 3'd5;
   localparam logic [2:0] RUN    = 3'd6;
   localparam logic [2:0] DRAIN  = 3'd7;

   localparam logic [PE_LOG:0] PE_FULL = (PE_LOG+1)'(PE_SIZE);

   logic [2:0]             state_q, state_d;
   logic                   cmd_rdy_q, cmd_rdy_d;
   logic                   t_rdy_q, t_rdy_d;
   logic                   s_rdy_q, s_rdy_d;
   logic                   set_t_q, set_t_d;
   logic                   start_q, start_d;
   logic                   pv_q, pv_d;
   logic [17:0]            t_q, t_d;
   logic [MATCH_BIT-1:0]   match_q, match_d, mism_q, mism_d;
   logic [7:0]             alpha_q, alpha_d, beta_q, beta_d;
   logic [2*PE_SIZE-1:0]   s_out_q, s_out_d;
   logic [PE_LOG:0]        s_vld_q, s_vld_d;
   logic [VEF_BIT-1:0]     res_q, res_d;
   logic                   res_vld_q, res_vld_d;
   logic                   err_q, err_d;
   logic                   first_q, first_d;
   logic [2:0]             tw_cnt_q, tw_cnt_d;
   logic                   seen_q, seen_d;
   logic [2*PE_SIZE-1:0]   buf_q, buf_d;
   logic [PE_LOG:0]        cnt_q, cnt_d;
   logic                   end_q, end_d;
   logic                   pend_q, pend_d;

   logic                   cmd_xfer, s_take, chunk_rdy;
   logic [PE_LOG-1:0]      idx;

   always_comb begin
      state_d   = state_q;
      set_t_d   = 1'b0;
      start_d   = 1'b0;
      pv_d      = 1'b0;
      t_d       = t_q;
      match_d   = match_q;
      mism_d    = mism_q;
      alpha_d   = alpha_q;
      beta_d    = beta_q;
      s_out_d   = '0;
      s_vld_d   = '0;
      res_d     = res_q;
      res_vld_d = 1'b0;
      err_d     = err_q;
      t_rdy_d   = t_rdy_q;
      first_d   = first_q;
      tw_cnt_d  = tw_cnt_q;
      seen_d    = seen_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      end_d     = end_q;
      pend_d    = pend_q;

      cmd_xfer  = cmd_valid_i && cmd_rdy_q;
      s_take    = s_valid_i && s_rdy_q;
      // An exhausted stream (end seen, nothing buffered) is also "ready": the
      // response is then a zero-count chunk marking end of S.
      chunk_rdy = (cnt_q == PE_FULL) || end_q;
      idx       = cnt_q[PE_LOG-1:0];

      // s_rdy_q is low whenever chunk_rdy is high, so a capture never
      // coincides with a chunk hand-off below.
      if (s_take) begin
         buf_d[{idx, 1'b0} +: 2] = s_base_i;
         cnt_d = cnt_q + 1'b1;
         if (s_last_i) end_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (cmd_xfer) begin
               case (cmd_op_i)
                  2'd0: begin
                     state_d = PARAM;
                     pv_d    = 1'b1;
                     match_d = cfg_match_i;
                     mism_d  = cfg_mismatch_i;
                     alpha_d = cfg_alpha_i;
                     beta_d  = cfg_beta_i;
                  end
                  2'd1: begin
                     state_d = TLOAD;
                     t_rdy_d = 1'b1;
                     first_d = 1'b1;
                  end
                  2'd2: begin
                     state_d = RSTART;
                     start_d = 1'b1;
                     buf_d   = '0;
                     cnt_d   = '0;
                     end_d   = 1'b0;
                     pend_d  = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         PARAM: state_d = IDLE;
         TLOAD: begin
            if (t_valid_i) begin
               t_d     = t_data_i;
               set_t_d = first_q;
               first_d = 1'b0;
               if (t_last_i) begin
                  t_rdy_d = 1'b0;
                  state_d = TEND;
               end
            end else if (!first_q) begin
               // gap mid-stream: terminate right away, terminator goes out now
               err_d   = 1'b1;
               t_d     = '0;
               t_rdy_d = 1'b0;
               state_d = TEND;
            end
         end
         TEND: begin
            t_d      = '0;
            state_d  = TWAIT;
            tw_cnt_d = 3'd4;
            seen_d   = 1'b0;
         end
         TWAIT: begin
            if (acc_busy_i) begin
               seen_d = 1'b1;
            end else if (seen_q || tw_cnt_q == 3'd1) begin
               state_d = IDLE;
            end else begin
               tw_cnt_d = tw_cnt_q - 3'd1;
            end
         end
         RSTART: state_d = RUN;
         RUN: begin
            if (acc_valid_i) begin
               res_d     = acc_result_i;
               res_vld_d = 1'b1;
               pend_d    = 1'b0;
               state_d   = DRAIN;
            end else if ((acc_request_s_i || pend_q) && chunk_rdy) begin
               s_out_d = buf_q;
               s_vld_d = cnt_q;
               buf_d   = '0;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else if (acc_request_s_i) begin
               pend_d = 1'b1;
            end
         end
         DRAIN: begin
            if (!acc_busy_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      s_rdy_d   = (state_d == RSTART || state_d == RUN) && !end_d && (cnt_d != PE_FULL);
      cmd_rdy_d = (state_d == IDLE) && !acc_busy_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cmd_rdy_q <= 1'b0;
         t_rdy_q   <= 1'b0;
         s_rdy_q   <= 1'b0;
         set_t_q   <= 1'b0;
         start_q   <= 1'b0;
         pv_q      <= 1'b0;
         t_q       <= '0;
         match_q   <= MATCH_BIT'(6);
         mism_q    <= MATCH_BIT'(1);
         alpha_q   <= 8'd2;
         beta_q    <= 8'd1;
         s_out_q   <= '0;
         s_vld_q   <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         err_q     <= 1'b0;
         first_q   <= 1'b0;
         tw_cnt_q  <= '0;
         seen_q    <= 1'b0;
         buf_q     <= '0;
         cnt_q     <= '0;
         end_q     <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_rdy_q <= cmd_rdy_d;
         t_rdy_q   <= t_rdy_d;
         s_rdy_q   <= s_rdy_d;
         set_t_q   <= set_t_d;
         start_q   <= start_d;
         pv_q      <= pv_d;
         t_q       <= t_d;
         match_q   <= match_d;
         mism_q    <= mism_d;
         alpha_q   <= alpha_d;
         beta_q    <= beta_d;
         s_out_q   <= s_out_d;
         s_vld_q   <= s_vld_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         err_q     <= err_d;
         first_q   <= first_d;
         tw_cnt_q  <= tw_cnt_d;
         seen_q    <= seen_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         end_q     <= end_d;
         pend_q    <= pend_d;
      end
   end

   assign cmd_ready_o       = cmd_rdy_q;
   assign t_ready_o         = t_rdy_q;
   assign s_ready_o         = s_rdy_q;
   assign acc_set_t_o       = set_t_q;
   assign acc_start_cal_o   = start_q;
   assign acc_param_valid_o = pv_q;
   assign acc_t_o           = t_q;
   assign acc_match_o       = match_q;
   assign acc_mismatch_o    = mism_q;
   assign acc_alpha_o       = alpha_q;
   assign acc_beta_o        = beta_q;
   assign acc_s_o           = s_out_q;
   assign acc_s_valid_o     = s_vld_q;
   assign res_data_o        = res_q;
   assign res_valid_o       = res_vld_q;
   assign err_o             = err_q;

endmodule
